// File: rtl/ascii_field_parser_if.sv
// Byte-stream in / parsed-frame out bundle for ascii_field_parser.
// master = the parser, slave = the FIFO plus the frame consumer.
interface ascii_field_parser_if #(
    parameter int DATA_W = 32
);
    logic              fifo_empty;
    logic [7:0]        fifo_dout;
    logic              fifo_rdreq;
    logic [DATA_W-1:0] frame_data;
    logic              frame_valid;
    logic              frame_ready;
    logic              err_pulse;
    logic [2:0]        err_code;

    modport master (
        input  fifo_empty, fifo_dout, frame_ready,
        output fifo_rdreq, frame_data, frame_valid, err_pulse, err_code
    );

    modport slave (
        output fifo_empty, fifo_dout, frame_ready,
        input  fifo_rdreq, frame_data, frame_valid, err_pulse, err_code
    );
endinterface

// File: rtl/ascii_field_parser.sv
// Parses lines of comma-separated ASCII decimal fields from a show-ahead
// RX FIFO into binary values, with per-frame error reporting.
//
// state | meaning
// PARSE | consume bytes, accumulate digits and fields
// FLUSH | rejected frame; discard bytes through the terminator
// HOLD  | complete frame presented; wait for frame_ready
module ascii_field_parser #(
    parameter int         OUT_W      = 16,
    parameter int         MAX_DIGITS = 5,
    parameter int         NUM_FIELDS = 2,
    parameter logic [7:0] DELIM      = 8'h2C,
    parameter logic [7:0] TERM       = 8'h0A
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ascii_field_parser_if.master  bus
);
    localparam int FW     = NUM_FIELDS * OUT_W;
    localparam int ACC_W  = OUT_W + 4;
    localparam int DCNT_W = $clog2(MAX_DIGITS + 1);
    localparam int FIDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam logic [FIDX_W-1:0] LAST_FIELD = FIDX_W'(NUM_FIELDS - 1);
    localparam logic [DCNT_W-1:0] DCNT_MAX   = DCNT_W'(MAX_DIGITS);
    localparam logic [7:0]        CR         = 8'h0D;

    typedef enum logic [1:0] {PARSE, FLUSH, HOLD} state_t;

    state_t            state;
    logic [OUT_W-1:0]  acc;
    logic [DCNT_W-1:0] dcnt;
    logic [FIDX_W-1:0] fidx;
    logic [FW-1:0]     shadow;
    logic [FW-1:0]     merged;
    logic [ACC_W-1:0]  prod;
    logic              is_digit;

    // Pop whenever the parser can take a byte; held off during reset so a
    // preloaded FIFO is not drained while the block is being reset.
    assign bus.fifo_rdreq = rst_n && (state == PARSE || state == FLUSH) && !bus.fifo_empty;

    // Widened multiply-add so overflow is detected instead of wrapping;
    // for '0'..'9' the low nibble is exactly byte - 8'h30.
    assign is_digit = (bus.fifo_dout >= 8'h30) && (bus.fifo_dout <= 8'h39);
    assign prod     = {4'b0000, acc} * ACC_W'(10) + {{(ACC_W-4){1'b0}}, bus.fifo_dout[3:0]};

    // Shadow register with the current accumulator dropped into the active field slot.
    always_comb begin
        merged = shadow;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (fidx == FIDX_W'(i)) merged[i*OUT_W +: OUT_W] = acc;
        end
    end

    // Parser FSM with registered frame and error outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= PARSE;
            acc             <= '0;
            dcnt            <= '0;
            fidx            <= '0;
            shadow          <= '0;
            bus.frame_data  <= '0;
            bus.frame_valid <= 1'b0;
            bus.err_pulse   <= 1'b0;
            bus.err_code    <= 3'd0;
        end else begin
            bus.err_pulse <= 1'b0;
            case (state)
                PARSE: begin
                    if (!bus.fifo_empty) begin
                        if (is_digit) begin
                            // Digit-count check wins over overflow so a long
                            // field reports as too many digits.
                            if (dcnt == DCNT_MAX) begin
                                bus.err_pulse <= 1'b1;
                                bus.err_code  <= 3'd2;
                                state         <= FLUSH;
                            end else if (prod[ACC_W-1:OUT_W] != '0) begin
                                bus.err_pulse <= 1'b1;
                                bus.err_code  <= 3'd3;
                                state         <= FLUSH;
                            end else begin
                                acc  <= prod[OUT_W-1:0];
                                dcnt <= dcnt + DCNT_W'(1);
                            end
                        end else if (bus.fifo_dout == CR) begin
                            state <= PARSE;
                        end else if (bus.fifo_dout == DELIM) begin
                            if (dcnt == '0) begin
                                bus.err_pulse <= 1'b1;
                                bus.err_code  <= 3'd4;
                                state         <= FLUSH;
                            end else if (fidx == LAST_FIELD) begin
                                bus.err_pulse <= 1'b1;
                                bus.err_code  <= 3'd5;
                                state         <= FLUSH;
                            end else begin
                                shadow <= merged;
                                fidx   <= fidx + FIDX_W'(1);
                                acc    <= '0;
                                dcnt   <= '0;
                            end
                        end else if (bus.fifo_dout == TERM) begin
                            if (dcnt == '0 && fidx == '0) begin
                                state <= PARSE;
                            end else if (dcnt == '0 || fidx != LAST_FIELD) begin
                                // Terminator already consumed: restart directly.
                                bus.err_pulse <= 1'b1;
                                bus.err_code  <= (dcnt == '0) ? 3'd4 : 3'd6;
                                acc           <= '0;
                                dcnt          <= '0;
                                fidx          <= '0;
                                state         <= PARSE;
                            end else begin
                                bus.frame_data  <= merged;
                                bus.frame_valid <= 1'b1;
                                state           <= HOLD;
                            end
                        end else begin
                            bus.err_pulse <= 1'b1;
                            bus.err_code  <= 3'd1;
                            state         <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (!bus.fifo_empty && bus.fifo_dout == TERM) begin
                        acc   <= '0;
                        dcnt  <= '0;
                        fidx  <= '0;
                        state <= PARSE;
                    end
                end
                HOLD: begin
                    if (bus.frame_valid && bus.frame_ready) begin
                        bus.frame_valid <= 1'b0;
                        acc             <= '0;
                        dcnt            <= '0;
                        fidx            <= '0;
                        state           <= PARSE;
                    end
                end
                default: state <= PARSE;
            endcase
        end
    end
endmodule

// File: tb/tb_ascii_field_parser.sv
// Directed bench for ascii_field_parser: a queue models the show-ahead FIFO,
// a table of ASCII lines carries the expected frame or error per line.
module tb_ascii_field_parser;
    logic clk;
    logic rst_n;

    ascii_field_parser_if #(.DATA_W(32)) bus ();

    ascii_field_parser dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       txt;
        bit          exp_frame;
        int          exp_errs;
        logic [2:0]  exp_code;
        logic [31:0] exp_data;
    } vec_t;

    vec_t        vecs[13];
    byte         q[$];
    logic        pop_pending = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          err_count = 0;
    logic [2:0]  last_code = 3'd0;
    logic [31:0] prev_data = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        bus.fifo_empty = (q.size() == 0);
        bus.fifo_dout  = (q.size() != 0) ? q[0] : 8'h00;
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        refresh();
    endtask

    // FIFO model: sample the pop request just before the edge, pop just after.
    always begin
        @(negedge clk);
        #4;
        pop_pending = bus.fifo_rdreq;
    end

    always @(posedge clk) begin
        #1;
        if (pop_pending && q.size() != 0) void'(q.pop_front());
        refresh();
    end

    always @(negedge clk) begin
        if (rst_n && bus.err_pulse) begin
            err_count++;
            last_code = bus.err_code;
        end
    end

    task automatic run_vec(input int idx);
        vec_t v;
        int   e0;
        int   cyc;
        v   = vecs[idx];
        e0  = err_count;
        cyc = 0;
        push_str(v.txt);
        @(negedge clk);
        while ((q.size() != 0 || bus.fifo_rdreq) && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        check($sformatf("v%0d_drain_timeout", idx), 32'(cyc >= 300), 32'd0);
        check($sformatf("v%0d_err_count", idx), 32'(err_count - e0), 32'(v.exp_errs));
        if (v.exp_errs > 0)
            check($sformatf("v%0d_err_code", idx), 32'(last_code), 32'(v.exp_code));
        check($sformatf("v%0d_frame_valid", idx), 32'(bus.frame_valid), 32'(v.exp_frame));
        check($sformatf("v%0d_frame_data", idx), bus.frame_data,
              v.exp_frame ? v.exp_data : prev_data);
        if (v.exp_frame) begin
            prev_data = v.exp_data;
            bus.frame_ready = 1'b1;
            @(negedge clk);
            check($sformatf("v%0d_valid_clear", idx), 32'(bus.frame_valid), 32'd0);
            bus.frame_ready = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int npop;
        int bad;
        int cyc;

        vecs[0]  = '{"1234,56\n",     1'b1, 0, 3'd0, 32'h0038_04D2};
        vecs[1]  = '{"65535,0\r\n",   1'b1, 0, 3'd0, 32'h0000_FFFF};
        vecs[2]  = '{"65536,0\n",     1'b0, 1, 3'd3, 32'h0};
        vecs[3]  = '{"12a4,5\n7,8\n", 1'b1, 1, 3'd1, 32'h0008_0007};
        vecs[4]  = '{"123456,1\n",    1'b0, 1, 3'd2, 32'h0};
        vecs[5]  = '{"5\n",           1'b0, 1, 3'd6, 32'h0};
        vecs[6]  = '{"1,,2\n",        1'b0, 1, 3'd4, 32'h0};
        vecs[7]  = '{"1,2,3\n",       1'b0, 1, 3'd5, 32'h0};
        vecs[8]  = '{"\n",            1'b0, 0, 3'd0, 32'h0};
        vecs[9]  = '{"99999,0\n",     1'b0, 1, 3'd3, 32'h0};
        vecs[10] = '{"0,00065\n",     1'b1, 0, 3'd0, 32'h0041_0000};
        vecs[11] = '{"1,2\r\r\n",     1'b1, 0, 3'd0, 32'h0002_0001};
        vecs[12] = '{"1,\n",          1'b0, 1, 3'd4, 32'h0};

        rst_n           = 1'b0;
        bus.frame_ready = 1'b0;
        refresh();
        repeat (3) @(negedge clk);

        // Preloaded FIFO under reset: nothing popped, outputs at reset values.
        push_str("1234,56\n");
        #1;
        check("rst_rdreq", 32'(bus.fifo_rdreq), 32'd0);
        check("rst_valid", 32'(bus.frame_valid), 32'd0);
        check("rst_data", bus.frame_data, 32'h0);
        check("rst_err_pulse", 32'(bus.err_pulse), 32'd0);
        check("rst_err_code", 32'(bus.err_code), 32'd0);
        rst_n = 1'b1;
        #1;

        npop = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.fifo_rdreq) npop++;
            @(negedge clk);
        end
        check("consecutive_pops", 32'(npop), 32'd8);
        check("first_valid", 32'(bus.frame_valid), 32'd1);
        check("first_data", bus.frame_data, 32'h0038_04D2);

        // Second line waits in the FIFO while the first frame is held.
        push_str("9,9\n");
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.fifo_rdreq || !bus.frame_valid || q.size() != 4 ||
                bus.frame_data !== 32'h0038_04D2) bad++;
        end
        check("hold_stall", 32'(bad), 32'd0);
        bus.frame_ready = 1'b1;
        @(negedge clk);
        check("first_valid_clear", 32'(bus.frame_valid), 32'd0);
        bus.frame_ready = 1'b0;

        cyc = 0;
        while (!bus.frame_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("second_valid", 32'(bus.frame_valid), 32'd1);
        check("second_data", bus.frame_data, 32'h0009_0009);
        bus.frame_ready = 1'b1;
        @(negedge clk);
        bus.frame_ready = 1'b0;
        check("no_errors_so_far", 32'(err_count), 32'd0);
        prev_data = 32'h0009_0009;

        for (int i = 0; i < 13; i++) run_vec(i);

        // Reset in the middle of a frame: the partial "12,3" must vanish.
        push_str("12,3");
        cyc = 0;
        while (q.size() != 0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_data", bus.frame_data, 32'h0);
        prev_data = 32'h0;
        vecs[0] = '{"4,5\n", 1'b1, 0, 3'd0, 32'h0005_0004};
        run_vec(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
